// File: rtl/shift_arbiter.sv
// shift_arbiter
//
// Shares one external combinational barrel shifter between two requesters:
// port 0 is the ALU operand-2 path, port 1 is the load/store address-offset
// path. Requests are arbitrated round-robin. The winner's operands are latched
// onto the shifter inputs, the shifter is given SETTLE_CYCLES edges to settle,
// and its output is then captured and returned with a one-cycle strobe tagged
// with the requester ID.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. reqN_ready is combinational, is only ever high in
// IDLE, and is never high for both requesters at once. A requester keeps its
// operands stable while valid is high and ready is low; it may drop valid
// before ready without any transfer. The response has no backpressure: the
// consumer must take rsp_* in the single cycle rsp_valid is high.
//
// Parameters:
//   SETTLE_CYCLES  edges spent in WAIT before sampling the shifter (0 acts as 1)
//   CNT_W          width of the grant counters (statistics build only)
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req0_* / req1_*          valid, ready, data[31:0], num[7:0], op[2:0], cin
//   sh_data/num/op/cin       registered operands driven to the shifter
//   sh_out, sh_cout          shifter result and carry-out
//   rsp_valid                one-cycle result strobe
//   rsp_id                   requester that owns the result
//   rsp_data, rsp_cout       captured shifter result and carry-out
//   dbg_state                current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//   gnt0_cnt, gnt1_cnt       saturating accept counters, present only when
//                            SHIFT_ARB_STATS_EN is defined

module shift_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [7:0]       req0_num,
  input  logic [2:0]       req0_op,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [7:0]       req1_num,
  input  logic [2:0]       req1_op,
  input  logic             req1_cin,
  output logic [31:0]      sh_data,
  output logic [7:0]       sh_num,
  output logic [2:0]       sh_op,
  output logic             sh_cin,
  input  logic [31:0]      sh_out,
  input  logic             sh_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_cout,
  output logic [1:0]       dbg_state
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  // A settle time of zero would sample the shifter in the same edge that
  // drives it, so it is promoted to one.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SW         = $clog2(SETTLE_EFF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rr_ptr;
  logic [SW-1:0] settle_cnt;
  logic          grant;
  logic          accept;

  // Winner: a lone valid requester wins outright; on contention rr_ptr decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr_ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == ST_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: if (settle_cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= 1'b0;
      settle_cnt <= '0;
      sh_data    <= '0;
      sh_num     <= '0;
      sh_op      <= '0;
      sh_cin     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      // The strobe is only raised by the WAIT->RESP edge below, so it is
      // low again on the edge that leaves RESP.
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sh_data    <= grant ? req1_data : req0_data;
            sh_num     <= grant ? req1_num  : req0_num;
            sh_op      <= grant ? req1_op   : req0_op;
            sh_cin     <= grant ? req1_cin  : req0_cin;
            rsp_id     <= grant;
            rr_ptr     <= ~grant;
            settle_cnt <= SW'(SETTLE_EFF - 1);
          end
        end
        ST_WAIT: begin
          if (settle_cnt == '0) begin
            rsp_data  <= sh_out;
            rsp_cout  <= sh_cout;
            rsp_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // Accept counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (req0_ready && (gnt0_cnt != '1)) gnt0_cnt <= gnt0_cnt + 1'b1;
      if (req1_ready && (gnt1_cnt != '1)) gnt1_cnt <= gnt1_cnt + 1'b1;
    end
  end
`else
  // CNT_W only sizes the counters; keep it referenced in the plain build.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter. Two instances run side by side: instance 0
// with SETTLE_CYCLES=1 / CNT_W=16 and instance 1 with SETTLE_CYCLES=3 /
// CNT_W=2. Each instance has a behavioural shifter stub on its sh_* bus and a
// reference model that predicts ready, the shifter bus, responses and the
// grant counters from the arbitration rules.

module tb_shift_arbiter;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst [2];
  int   ncyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- signals
  logic        rq_valid [2][2];
  logic        rq_ready [2][2];
  logic [31:0] rq_data  [2][2];
  logic [7:0]  rq_num   [2][2];
  logic [2:0]  rq_op    [2][2];
  logic        rq_cin   [2][2];

  logic [31:0] sh_data  [2];
  logic [7:0]  sh_num   [2];
  logic [2:0]  sh_op    [2];
  logic        sh_cin   [2];
  logic        rsp_valid[2];
  logic        rsp_id   [2];
  logic [31:0] rsp_data [2];
  logic        rsp_cout [2];
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] gcnt0 [2];
  logic [15:0] gcnt1 [2];
`endif

  int n_tests;
  int n_fail;
  int gnt_log0[$];

  // ---------------------------------------------------------------- checker
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural shifter: op[2:1] selects LSL/LSR/ASR/ROR, applied one bit at a
  // time num times; carry is the last bit shifted out (cin if num is 0).
  // Immediate-form ROR by 0 is RRX.
  function automatic logic [32:0] shift_ref(input logic [31:0] d, input logic [7:0] n,
                                            input logic [2:0] op, input logic c);
    logic [31:0] r;
    logic        co;
    r  = d;
    co = c;
    if (op[2:1] == 2'b11 && !op[0] && n == 8'd0) begin
      co = d[0];
      r  = {c, d[31:1]};
    end else begin
      for (int k = 0; k < 256; k++) begin
        if (k < int'(n)) begin
          case (op[2:1])
            2'b00:   begin co = r[31]; r = {r[30:0], 1'b0}; end
            2'b01:   begin co = r[0];  r = {1'b0, r[31:1]}; end
            2'b10:   begin co = r[0];  r = {r[31], r[31:1]}; end
            default: begin co = r[0];  r = {r[0], r[31:1]}; end
          endcase
        end
      end
    end
    return {co, r};
  endfunction

  // ---------------------------------------------------------------- DUTs + models
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int S    = (g == 0) ? 1 : 3;
    localparam int CW   = (g == 0) ? 16 : 2;
    localparam int CMAX = (1 << CW) - 1;

    logic [31:0] so;
    logic        sc;
    logic [1:0]  unused_dbg_state;
`ifdef SHIFT_ARB_STATS_EN
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    assign gcnt0[g] = 16'(c0);
    assign gcnt1[g] = 16'(c1);
`endif

    assign {sc, so} = shift_ref(sh_data[g], sh_num[g], sh_op[g], sh_cin[g]);

    shift_arbiter #(.SETTLE_CYCLES(S), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req0_valid(rq_valid[g][0]),
      .req0_ready(rq_ready[g][0]),
      .req0_data (rq_data[g][0]),
      .req0_num  (rq_num[g][0]),
      .req0_op   (rq_op[g][0]),
      .req0_cin  (rq_cin[g][0]),
      .req1_valid(rq_valid[g][1]),
      .req1_ready(rq_ready[g][1]),
      .req1_data (rq_data[g][1]),
      .req1_num  (rq_num[g][1]),
      .req1_op   (rq_op[g][1]),
      .req1_cin  (rq_cin[g][1]),
      .sh_data   (sh_data[g]),
      .sh_num    (sh_num[g]),
      .sh_op     (sh_op[g]),
      .sh_cin    (sh_cin[g]),
      .sh_out    (so),
      .sh_cout   (sc),
      .rsp_valid (rsp_valid[g]),
      .rsp_id    (rsp_id[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_cout  (rsp_cout[g]),
      .dbg_state (unused_dbg_state)
`ifdef SHIFT_ARB_STATS_EN
      ,
      .gnt0_cnt  (c0),
      .gnt1_cnt  (c1)
`endif
    );

    // Scoreboard: expected {cout, data} per accepted request and the cycle
    // its strobe is due; the block is busy until free_at.
    logic [32:0] exp_q[$];
    int          due_q[$];
    int          free_at;
    logic        pref;
    logic [43:0] sh_exp;
    logic [32:0] last_rsp;
    logic        e_id;
    int          n0;
    int          n1;

    always @(negedge clk) begin : mon
      logic v0, v1, w, idle, er0, er1, ev;
      if (rst[g]) begin
        exp_q.delete();
        due_q.delete();
        free_at  = ncyc + 1;
        pref     = 1'b0;
        sh_exp   = '0;
        last_rsp = '0;
        e_id     = 1'b0;
        n0       = 0;
        n1       = 0;
      end else begin
        v0   = rq_valid[g][0];
        v1   = rq_valid[g][1];
        idle = (ncyc >= free_at);
        w    = (v0 && v1) ? pref : v1;
        er0  = idle && v0 && !w;
        er1  = idle && v1 && w;
        check_eq("req0_ready", 64'(rq_ready[g][0]), 64'(er0));
        check_eq("req1_ready", 64'(rq_ready[g][1]), 64'(er1));
        check_eq("sh_bus", 64'({sh_data[g], sh_num[g], sh_op[g], sh_cin[g]}), 64'(sh_exp));
        ev = (due_q.size() > 0) && (due_q[0] == ncyc);
        if (ev) begin
          last_rsp = exp_q.pop_front();
          void'(due_q.pop_front());
        end
        check_eq("rsp_valid", 64'(rsp_valid[g]), 64'(ev));
        check_eq("rsp_cout_data", 64'({rsp_cout[g], rsp_data[g]}), 64'(last_rsp));
        check_eq("rsp_id", 64'(rsp_id[g]), 64'(e_id));
`ifdef SHIFT_ARB_STATS_EN
        check_eq("gnt0_cnt", 64'(c0), 64'((n0 > CMAX) ? CMAX : n0));
        check_eq("gnt1_cnt", 64'(c1), 64'((n1 > CMAX) ? CMAX : n1));
`endif
        if (er0 || er1) begin
          sh_exp = {rq_data[g][w], rq_num[g][w], rq_op[g][w], rq_cin[g][w]};
          exp_q.push_back(shift_ref(rq_data[g][w], rq_num[g][w], rq_op[g][w], rq_cin[g][w]));
          due_q.push_back(ncyc + S + 1);
          free_at = ncyc + S + 2;
          pref    = ~w;
          e_id    = w;
          if (w) n1++;
          else n0++;
          if (g == 0) gnt_log0.push_back(int'(w));
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks are entered just after a rising edge.
  task automatic apply_reset(input int i);
    rst[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[i] = 1'b0;
  endtask

  // Raise valid with the given operands and hold until accepted. With
  // may_drop set, the request may be withdrawn early (acc_cyc stays -1).
  task automatic issue(input int i, input int p, input logic [31:0] d, input logic [7:0] n,
                       input logic [2:0] op, input logic c, input bit may_drop,
                       output int acc_cyc);
    acc_cyc        = -1;
    rq_valid[i][p] = 1'b1;
    rq_data[i][p]  = d;
    rq_num[i][p]   = n;
    rq_op[i][p]    = op;
    rq_cin[i][p]   = c;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rq_ready[i][p]) begin
        acc_cyc = ncyc;
        break;
      end
      if (may_drop && $urandom_range(0, 7) == 0) break;
    end
    @(posedge clk);
    #1;
    rq_valid[i][p] = 1'b0;
    if (!may_drop) check_eq("accepted", 64'(acc_cyc >= 0), 64'd1);
  endtask

  task automatic wait_rsp(input int i, output int rcyc);
    rcyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        rcyc = ncyc;
        break;
      end
    end
    check_eq("rsp_seen", 64'(rcyc >= 0), 64'd1);
  endtask

  task automatic rand_port(input int i, input int p, input int n);
    int acc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      issue(i, p, $urandom,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40)),
            3'($urandom), 1'($urandom), 1'b1, acc);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    int a0, a1, rc, rel;
    n_tests = 0;
    n_fail  = 0;
    ncyc    = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        rq_valid[i][p] = 1'b0;
        rq_data[i][p]  = '0;
        rq_num[i][p]   = '0;
        rq_op[i][p]    = '0;
        rq_cin[i][p]   = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Outputs straight after reset.
    @(negedge clk);
    check_eq("reset_rsp", 64'({rsp_valid[0], rsp_id[0], rsp_cout[0], rsp_data[0]}), 64'd0);
    check_eq("reset_sh", 64'({sh_data[0], sh_num[0], sh_op[0], sh_cin[0]}), 64'd0);
    check_eq("reset_ready", 64'({rq_ready[0][0], rq_ready[0][1]}), 64'd0);
    @(posedge clk);
    #1;

    // 1: lone req0, LSL #4.
    apply_reset(0);
    rel = ncyc;
    issue(0, 0, 32'hF000_0001, 8'd4, 3'b000, 1'b0, 1'b0, a0);
    check_eq("t1_ready_after_reset", 64'(a0), 64'(rel));
    wait_rsp(0, rc);
    check_eq("t1_latency", 64'(rc - a0 - 1), 64'd1);
    check_eq("t1_rsp_id", 64'(rsp_id[0]), 64'd0);
    check_eq("t1_rsp_data", 64'(rsp_data[0]), 64'h0000_0010);
    check_eq("t1_rsp_cout", 64'(rsp_cout[0]), 64'd1);
    @(posedge clk);
    #1;

    // 2: both valid from reset; req0 first, req1 at the next IDLE.
    apply_reset(0);
    fork
      issue(0, 0, 32'hF000_0001, 8'd4, 3'b000, 1'b0, 1'b0, a0);
      issue(0, 1, 32'h8000_0000, 8'd4, 3'b100, 1'b0, 1'b0, a1);
    join
    check_eq("t2_req1_after_req0", 64'(a1 - a0), 64'd3);
    wait_rsp(0, rc);
    check_eq("t2_rsp_id", 64'(rsp_id[0]), 64'd1);
    check_eq("t2_rsp_data", 64'(rsp_data[0]), 64'hF800_0000);
    @(posedge clk);
    #1;

    // 3: both held valid for six grants.
    apply_reset(0);
    gnt_log0.delete();
    fork
      repeat (3) issue(0, 0, 32'h0000_00FF, 8'd1, 3'b010, 1'b1, 1'b0, a0);
      repeat (3) issue(0, 1, 32'hA5A5_0000, 8'd3, 3'b110, 1'b0, 1'b0, a1);
    join
    repeat (4) @(posedge clk);
    #1;
    check_eq("t3_grants", 64'(gnt_log0.size()), 64'd6);
    for (int k = 0; k < gnt_log0.size(); k++)
      check_eq("t3_grant_order", 64'(gnt_log0[k]), 64'(k % 2));
`ifdef SHIFT_ARB_STATS_EN
    check_eq("t3_gnt0_cnt", 64'(gcnt0[0]), 64'd3);
    check_eq("t3_gnt1_cnt", 64'(gcnt1[0]), 64'd3);
`endif

    // 4: SETTLE_CYCLES=3, ROR #8 on req1.
    apply_reset(1);
    issue(1, 1, 32'h1234_5678, 8'd8, 3'b110, 1'b0, 1'b0, a1);
    wait_rsp(1, rc);
    check_eq("t4_latency", 64'(rc - a1 - 1), 64'd3);
    check_eq("t4_rsp_id", 64'(rsp_id[1]), 64'd1);
    check_eq("t4_rsp_data", 64'(rsp_data[1]), 64'h7812_3456);
    @(posedge clk);
    #1;

    // 5: reset while in WAIT abandons the transaction.
    apply_reset(1);
    issue(1, 0, 32'hDEAD_BEEF, 8'd5, 3'b011, 1'b1, 1'b0, a0);
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("t5_rsp_cleared", 64'({rsp_valid[1], rsp_id[1], rsp_cout[1], rsp_data[1]}), 64'd0);
    check_eq("t5_sh_cleared", 64'({sh_data[1], sh_num[1], sh_op[1], sh_cin[1]}), 64'd0);
    @(posedge clk);
    #1;
    fork
      issue(1, 0, 32'h0000_0001, 8'd31, 3'b000, 1'b0, 1'b0, a0);
      issue(1, 1, 32'h8000_0001, 8'd1, 3'b010, 1'b0, 1'b0, a1);
    join
    check_eq("t5_req0_first", 64'(a0 < a1), 64'd1);
    repeat (6) @(posedge clk);
    #1;

    // 6: five req0 accepts against a 2-bit counter.
    apply_reset(1);
    repeat (5) issue(1, 0, $urandom, 8'($urandom_range(0, 33)), 3'($urandom), 1'($urandom), 1'b0, a0);
    repeat (6) @(posedge clk);
    #1;
`ifdef SHIFT_ARB_STATS_EN
    check_eq("t6_gnt0_sat", 64'(gcnt0[1]), 64'd3);
    check_eq("t6_gnt1_cnt", 64'(gcnt1[1]), 64'd0);
`endif

    // Random traffic on both instances, including withdrawn requests.
    apply_reset(0);
    apply_reset(1);
    fork
      rand_port(0, 0, 40);
      rand_port(0, 1, 40);
      rand_port(1, 0, 40);
      rand_port(1, 1, 40);
    join
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
